// File: rtl/aes_block_source.sv
// aes_block_source: reads num_blocks 128-bit blocks from TCDM as four 32-bit
// word reads each and presents every assembled block on a valid/ready stream.
module aes_block_source #(
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 req_start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] num_blocks_i,
  output logic                 ready_start_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  input  logic                 tcdm_gnt_i,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [3:0]           tcdm_be_o,
  input  logic [31:0]          tcdm_r_data_i,
  input  logic                 tcdm_r_valid_i,
  output logic                 block_valid_o,
  input  logic                 block_ready_i,
  output logic [127:0]         block_data_o
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [2:0] NUM_WORDS = 3'(WORDS_PER_BLOCK);
  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

  state_t               state;
  state_t               state_next;
  logic [31:0]          addr;
  logic [CNT_WIDTH-1:0] num_blocks;
  logic [CNT_WIDTH-1:0] blk_cnt;
  logic [CNT_WIDTH-1:0] blk_cnt_inc;
  logic [2:0]           issue_cnt;
  logic [2:0]           resp_cnt;
  logic [3:0][31:0]     words;
  logic                 issue_fire;
  logic                 resp_fire;
  logic                 last_resp;
  logic                 last_block;

  assign blk_cnt_inc = blk_cnt + 1'b1;
  assign issue_fire  = tcdm_req_o & tcdm_gnt_i;
  // responses are only honoured while fetching; anything else is a stale reply
  assign resp_fire   = (state == FETCH) & tcdm_r_valid_i;
  assign last_resp   = resp_fire & (resp_cnt == LAST_WORD);
  assign last_block  = (blk_cnt_inc == num_blocks);

  assign tcdm_add_o   = addr;
  assign tcdm_wen_o   = 1'b1;
  assign tcdm_be_o    = '1;
  assign block_data_o = words;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_start_i) begin
          state_next = (num_blocks_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (last_resp) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (block_ready_i) begin
          state_next = last_block ? DONE : FETCH;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status and handshake outputs, decoded from registered state only
  always_comb begin
    ready_start_o = 1'b0;
    done_o        = 1'b0;
    tcdm_req_o    = 1'b0;
    block_valid_o = 1'b0;
    case (state)
      IDLE:    ready_start_o = 1'b1;
      FETCH:   tcdm_req_o    = (issue_cnt < NUM_WORDS);
      PRESENT: block_valid_o = 1'b1;
      DONE:    done_o        = 1'b1;
      default: ready_start_o = 1'b0;
    endcase
  end

  // Job parameters, address generation, counters and block assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      num_blocks <= '0;
      blk_cnt    <= '0;
      issue_cnt  <= '0;
      resp_cnt   <= '0;
      words      <= '0;
    end else if (clear) begin
      addr       <= '0;
      num_blocks <= '0;
      blk_cnt    <= '0;
      issue_cnt  <= '0;
      resp_cnt   <= '0;
      words      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_start_i) begin
            addr       <= base_addr_i & 32'hFFFF_FFFC;
            num_blocks <= num_blocks_i;
            blk_cnt    <= '0;
            issue_cnt  <= '0;
            resp_cnt   <= '0;
          end
        end
        FETCH: begin
          if (issue_fire) begin
            addr      <= addr + 32'd4;
            issue_cnt <= issue_cnt + 3'd1;
          end
          if (resp_fire) begin
            words[resp_cnt[1:0]] <= tcdm_r_data_i;
            resp_cnt             <= resp_cnt + 3'd1;
          end
        end
        PRESENT: begin
          if (block_ready_i) begin
            blk_cnt   <= blk_cnt_inc;
            issue_cnt <= '0;
            resp_cnt  <= '0;
          end
        end
        default: begin
          addr <= addr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_source.sv
// tb_aes_block_source: scoreboard bench; a job task pushes the expected word
// addresses and assembled blocks, a monitor pops and compares at handshakes.
module tb_aes_block_source;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          req_start_i;
  logic [31:0]   base_addr_i;
  logic [CW-1:0] num_blocks_i;
  logic          ready_start_o;
  logic          done_o;
  logic          tcdm_req_o;
  logic          tcdm_gnt_i;
  logic [31:0]   tcdm_add_o;
  logic          tcdm_wen_o;
  logic [3:0]    tcdm_be_o;
  logic [31:0]   tcdm_r_data_i;
  logic          tcdm_r_valid_i;
  logic          block_valid_o;
  logic          block_ready_i;
  logic [127:0]  block_data_o;

  aes_block_source #(
    .WORDS_PER_BLOCK(4),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .req_start_i(req_start_i),
    .base_addr_i(base_addr_i),
    .num_blocks_i(num_blocks_i),
    .ready_start_o(ready_start_o),
    .done_o(done_o),
    .tcdm_req_o(tcdm_req_o),
    .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o),
    .tcdm_r_data_i(tcdm_r_data_i),
    .tcdm_r_valid_i(tcdm_r_valid_i),
    .block_valid_o(block_valid_o),
    .block_ready_i(block_ready_i),
    .block_data_o(block_data_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          inj_cyc  = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0]  exp_addr_q [$];
  logic [127:0] exp_blk_q  [$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // TCDM memory model: one-cycle read latency after each accepted request
  logic        pend;
  logic [31:0] pend_a;
  always @(negedge clk) begin
    pend   = tcdm_req_o && tcdm_gnt_i && !reset;
    pend_a = tcdm_add_o;
  end
  always @(posedge clk) begin
    #1;
    tcdm_r_valid_i = pend || (inj_cyc == cyc);
    tcdm_r_data_i  = pend ? mem_word(pend_a) : ((inj_cyc == cyc) ? 32'hDEAD_BEEF : $urandom);
  end

  // Monitor: scoreboard pops plus protocol checks, sampled on the falling edge
  logic         hold_pend = 1'b0;
  logic [31:0]  hold_addr;
  logic         stall_pend = 1'b0;
  logic [127:0] stall_data;
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (hold_pend) begin
        check("req_held", tcdm_req_o, 1);
        check("add_held", tcdm_add_o, hold_addr);
      end
      if (stall_pend) begin
        check("valid_held", block_valid_o, 1);
        check("data_held", block_data_o, stall_data);
      end
      if (tcdm_req_o && tcdm_gnt_i) begin
        check("req_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check("req_addr", tcdm_add_o, exp_addr_q.pop_front());
        check("wen_be", {tcdm_wen_o, tcdm_be_o}, 5'h1F);
      end
      if (block_valid_o) begin
        check("valid_expected", exp_blk_q.size() != 0, 1);
        check("no_req_in_present", tcdm_req_o, 0);
      end
      if (block_valid_o && block_ready_i && exp_blk_q.size() != 0)
        check("block_data", block_data_o, exp_blk_q.pop_front());
      if (done_o) done_cnt++;
      hold_pend  = tcdm_req_o && !tcdm_gnt_i;
      hold_addr  = tcdm_add_o;
      stall_pend = block_valid_o && !block_ready_i;
      stall_data = block_data_o;
    end else begin
      hold_pend  = 1'b0;
      stall_pend = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_start"}, ready_start_o, 1);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_req"}, tcdm_req_o, 0);
    check({tag, "_add"}, tcdm_add_o, 0);
    check({tag, "_valid"}, block_valid_o, 0);
    check({tag, "_data"}, block_data_o, 0);
  endtask

  // gmode: 0 grant always, 1 random, 2 three-cycle stall on the second word
  // rmode: 0 ready always, 1 random, 2 five-cycle stall on block 0
  task automatic run_job(input logic [31:0] base, input int n, input int gmode,
                         input int rmode, input int exp_lat, input int restart_at);
    logic [31:0]  a;
    logic [127:0] blk;
    int t0, tdone, grants, accepts, gstall, rstall, d0;
    bit got_done;
    a = base & 32'hFFFF_FFFC;
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < 4; w++) begin
        exp_addr_q.push_back(a);
        blk[32*w +: 32] = mem_word(a);
        a = a + 32'd4;
      end
      exp_blk_q.push_back(blk);
    end
    @(posedge clk); #1;
    check("ready_before_start", ready_start_o, 1);
    req_start_i  = 1'b1;
    base_addr_i  = base;
    num_blocks_i = CW'(n);
    t0 = cyc; d0 = done_cnt; tdone = 0;
    got_done = 0; grants = 0; accepts = 0; gstall = 0; rstall = 0;
    for (int k = 0; k < 2000 && !got_done; k++) begin
      @(negedge clk);
      if (tcdm_req_o && tcdm_gnt_i) grants++;
      if (block_valid_o && block_ready_i) accepts++;
      if (done_o) begin
        got_done = 1;
        tdone = cyc;
        check("ready_low_in_done", ready_start_o, 0);
      end
      if (!got_done) begin
        @(posedge clk); #1;
        req_start_i = (cyc - t0 == restart_at);
        base_addr_i = base ^ 32'h0000_0100;
        case (gmode)
          0: tcdm_gnt_i = 1'b1;
          1: tcdm_gnt_i = ($urandom_range(0, 3) != 0);
          default: begin
            if (grants == 1 && tcdm_req_o && gstall < 3) begin
              tcdm_gnt_i = 1'b0;
              gstall++;
            end else tcdm_gnt_i = 1'b1;
          end
        endcase
        case (rmode)
          0: block_ready_i = 1'b1;
          1: block_ready_i = ($urandom_range(0, 2) != 0);
          default: begin
            if (accepts == 0 && block_valid_o && rstall < 5) begin
              block_ready_i = 1'b0;
              rstall++;
            end else block_ready_i = 1'b1;
          end
        endcase
      end
    end
    check("done_seen", got_done, 1);
    if (exp_lat >= 0) check("done_latency", tdone - t0, exp_lat);
    @(posedge clk); #1;
    req_start_i = 1'b0;
    @(negedge clk);
    check("idle_after_done", ready_start_o, 1);
    check("done_single_cycle", done_o, 0);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("addr_q_drained", exp_addr_q.size(), 0);
    check("blk_q_drained", exp_blk_q.size(), 0);
    exp_addr_q.delete();
    exp_blk_q.delete();
  endtask

  task automatic abort_job();
    exp_addr_q.push_back(32'h3000);
    exp_addr_q.push_back(32'h3004);
    @(posedge clk); #1;
    req_start_i = 1'b1; base_addr_i = 32'h3000; num_blocks_i = CW'(1);
    tcdm_gnt_i = 1'b1; block_ready_i = 1'b1;
    @(posedge clk); #1;
    req_start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tcdm_gnt_i = 1'b0;
    clear = 1'b1;
    inj_cyc = cyc + 1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    check("abort_late_valid_present", tcdm_r_valid_i, 1);
    @(negedge clk);
    check("abort_late_data_dropped", block_data_o, 0);
    check("abort_addr_q_drained", exp_addr_q.size(), 0);
    exp_addr_q.delete();
    tcdm_gnt_i = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; req_start_i = 1'b0; base_addr_i = '0;
    num_blocks_i = '0; tcdm_gnt_i = 1'b0; block_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    mem[32'h1000] = 32'h0011_2233;
    mem[32'h1004] = 32'h4455_6677;
    mem[32'h1008] = 32'h8899_AABB;
    mem[32'h100C] = 32'hCCDD_EEFF;
    run_job(32'h1000, 1, 0, 0, 7, -1);
    run_job(32'h1000, 1, 2, 0, 10, -1);
    run_job(32'h1000, 2, 0, 2, 18, -1);
    run_job(32'h1000, 0, 0, 0, 1, -1);
    abort_job();
    run_job(32'h2000, 1, 0, 0, 7, -1);
    run_job(32'hFFFF_FFF8, 1, 0, 0, 7, 2);
    for (int j = 0; j < 8; j++)
      run_job($urandom, $urandom_range(1, 4), 1, 1, -1, -1);
    run_job(32'h0000_4003, 3, 0, 0, 19, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
